// File: rtl/v_chunk_collect.sv
// Reassembles a chunked vector stream (WorkingRegs lanes per strobe) into one
// VecLength-element vector and holds it until the downstream stage acknowledges.
//
// state   | meaning
// FILLING | accepting chunks; in_ready high, out_vector not yet complete
// HOLDING | full vector presented; chunks are dropped until out_vector_ack
module v_chunk_collect #(
   parameter int VecLength   = 16,
   parameter int WorkingRegs = 4,
   parameter int NBits       = 8
) (
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic                                in_chunk_valid,
   input  logic signed [WorkingRegs*NBits-1:0] in_chunk_data,
   output logic                                in_ready,
   output logic signed [VecLength*NBits-1:0]   out_vector,
   output logic                                out_vector_valid,
   input  logic                                out_vector_ack,
   output logic [$clog2(VecLength):0]          chunk_count,
   output logic                                drop_err
);

   localparam int CW = $clog2(VecLength) + 1;

   typedef enum logic {
      FILLING = 1'b0,
      HOLDING = 1'b1
   } state_t;

   state_t            state_q;
   logic [CW-1:0]     wr_idx_q;
   logic [CW-1:0]     wr_idx_d;
   logic [CW-1:0]     chunk_count_q;
   logic              drop_err_q;
   logic [NBits-1:0]  vec_q [VecLength];
   logic [NBits-1:0]  vec_d [VecLength];
   logic              accept;
   logic              last_chunk;

   assign in_ready   = (state_q == FILLING);
   assign accept     = in_chunk_valid && in_ready;
   assign last_chunk = (int'(wr_idx_q) + WorkingRegs >= VecLength);
   assign wr_idx_d   = last_chunk ? '0 : wr_idx_q + CW'(WorkingRegs);

   // Lane i lands on element wr_idx+i; lanes past the vector end match no element.
   always_comb begin
      vec_d = vec_q;
      for (int j = 0; j < VecLength; j++) begin
         for (int i = 0; i < WorkingRegs; i++) begin
            if (accept && (int'(wr_idx_q) + i == j)) begin
               vec_d[j] = in_chunk_data[i*NBits +: NBits];
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q       <= FILLING;
         wr_idx_q      <= '0;
         chunk_count_q <= '0;
         drop_err_q    <= 1'b0;
         for (int j = 0; j < VecLength; j++) begin
            vec_q[j] <= '0;
         end
      end else begin
         vec_q <= vec_d;
         if (in_chunk_valid && !in_ready) begin
            drop_err_q <= 1'b1;
         end
         case (state_q)
            FILLING: begin
               if (in_chunk_valid) begin
                  chunk_count_q <= chunk_count_q + CW'(1);
                  wr_idx_q      <= wr_idx_d;
                  if (last_chunk) begin
                     state_q <= HOLDING;
                  end
               end
            end
            HOLDING: begin
               if (out_vector_ack) begin
                  state_q       <= FILLING;
                  chunk_count_q <= '0;
               end
            end
            default: state_q <= FILLING;
         endcase
      end
   end

   for (genvar g = 0; g < VecLength; g++) begin : g_flat
      assign out_vector[g*NBits +: NBits] = vec_q[g];
   end

   assign out_vector_valid = (state_q == HOLDING);
   assign chunk_count      = chunk_count_q;
   assign drop_err         = drop_err_q;

endmodule

// File: tb/tb_v_chunk_collect.sv
// Bench for v_chunk_collect: two instances (10x4 and 3x4 lanes of 8 bits), an
// element-queue reference model checked every cycle, plus literal expectations.
module tb_v_chunk_collect;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit armed  = 1'b0;

   logic        a_rst, a_v, a_ack;
   logic [31:0] a_d;
   logic        a_rdy, a_ov, a_drop;
   logic [79:0] a_vec;
   logic [4:0]  a_cnt;

   logic        b_rst, b_v, b_ack;
   logic [31:0] b_d;
   logic        b_rdy, b_ov, b_drop;
   logic [23:0] b_vec;
   logic [2:0]  b_cnt;

   v_chunk_collect #(.VecLength(10), .WorkingRegs(4), .NBits(8)) dut_a (
      .clk_in(clk), .rst_in(a_rst), .in_chunk_valid(a_v), .in_chunk_data(a_d),
      .in_ready(a_rdy), .out_vector(a_vec), .out_vector_valid(a_ov),
      .out_vector_ack(a_ack), .chunk_count(a_cnt), .drop_err(a_drop));

   v_chunk_collect #(.VecLength(3), .WorkingRegs(4), .NBits(8)) dut_b (
      .clk_in(clk), .rst_in(b_rst), .in_chunk_valid(b_v), .in_chunk_data(b_d),
      .in_ready(b_rdy), .out_vector(b_vec), .out_vector_valid(b_ov),
      .out_vector_ack(b_ack), .chunk_count(b_cnt), .drop_err(b_drop));

   // Reference model: accepted lanes are appended to a pending element list;
   // once VecLength elements have accumulated they become the held vector.
   int mvec [2][16];
   int pend [2][16];
   int pn   [2];
   int mcnt [2];
   bit mhold[2];
   bit mdrop[2];

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_step(int d, int vl, logic r, logic v, logic [31:0] data, logic ack);
      if (r) begin
         mhold[d] = 1'b0;
         mdrop[d] = 1'b0;
         pn[d]    = 0;
         mcnt[d]  = 0;
         for (int j = 0; j < 16; j++) mvec[d][j] = 0;
      end else if (mhold[d]) begin
         if (v) mdrop[d] = 1'b1;
         if (ack) begin
            mhold[d] = 1'b0;
            mcnt[d]  = 0;
         end
      end else if (v) begin
         for (int i = 0; i < 4; i++) begin
            if (pn[d] < vl) begin
               pend[d][pn[d]] = int'($signed(data[i*8 +: 8]));
               pn[d]++;
            end
         end
         mcnt[d]++;
         if (pn[d] == vl) begin
            for (int j = 0; j < vl; j++) mvec[d][j] = pend[d][j];
            mhold[d] = 1'b1;
            pn[d]    = 0;
         end
      end
   endtask

   function automatic logic [127:0] model_vec(int d, int vl);
      logic [127:0] r;
      int e;
      r = '0;
      for (int j = 0; j < vl; j++) begin
         e = mvec[d][j];
         r[j*8 +: 8] = e[7:0];
      end
      return r;
   endfunction

   task automatic cmp_dut(string p, int d, int vl, logic rdy, logic ov, int cnt,
                          logic drop, logic [127:0] vec);
      chk({p, ".ready"}, 128'(rdy), 128'(!mhold[d]));
      chk({p, ".valid"}, 128'(ov), 128'(mhold[d]));
      chk({p, ".count"}, 128'(cnt), 128'(mcnt[d]));
      chk({p, ".drop"},  128'(drop), 128'(mdrop[d]));
      if (mhold[d]) chk({p, ".vector"}, vec, model_vec(d, vl));
   endtask

   always @(posedge clk) begin
      model_step(0, 10, a_rst, a_v, a_d, a_ack);
      model_step(1, 3,  b_rst, b_v, b_d, b_ack);
   end

   always @(negedge clk) begin
      if (armed) begin
         cmp_dut("A", 0, 10, a_rdy, a_ov, int'(a_cnt), a_drop, {48'b0, a_vec});
         cmp_dut("B", 1, 3,  b_rdy, b_ov, int'(b_cnt), b_drop, {104'b0, b_vec});
      end
   end

   function automatic logic [31:0] ch(int l0, int l1, int l2, int l3);
      return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
   endfunction

   function automatic logic [127:0] seqv(int s, int n);
      logic [127:0] r;
      int e;
      r = '0;
      for (int j = 0; j < n; j++) begin
         e = s + j;
         r[j*8 +: 8] = e[7:0];
      end
      return r;
   endfunction

   task automatic a_send(logic [31:0] d);
      a_v = 1'b1;
      a_d = d;
      @(negedge clk);
      a_v = 1'b0;
   endtask

   task automatic a_ack_pulse();
      a_ack = 1'b1;
      @(negedge clk);
      a_ack = 1'b0;
   endtask

   initial begin
      a_rst = 1'b1; a_v = 1'b0; a_ack = 1'b0; a_d = '0;
      b_rst = 1'b1; b_v = 1'b0; b_ack = 1'b0; b_d = '0;
      @(negedge clk);
      armed = 1'b1;
      chk("A.rst_vec",   {48'b0, a_vec}, '0);
      chk("A.rst_ready", 128'(a_rdy), 128'(1));
      chk("A.rst_cnt",   128'(a_cnt), '0);
      chk("B.rst_vec",   {104'b0, b_vec}, '0);
      a_rst = 1'b0;
      b_rst = 1'b0;

      // three back-to-back chunks, surplus lanes 11 and 12 discarded
      a_send(ch(1, 2, 3, 4));
      a_send(ch(5, 6, 7, 8));
      a_send(ch(9, 10, 11, 12));
      chk("A.t1_vec",   {48'b0, a_vec}, seqv(1, 10));
      chk("A.t1_cnt",   128'(a_cnt), 128'(3));
      chk("A.t1_valid", 128'(a_ov), 128'(1));
      chk("A.t1_ready", 128'(a_rdy), 128'(0));
      repeat (5) begin
         @(negedge clk);
         chk("A.hold_vec",   {48'b0, a_vec}, seqv(1, 10));
         chk("A.hold_valid", 128'(a_ov), 128'(1));
      end

      // strobe while holding is dropped
      a_send(ch(99, 99, 99, 99));
      chk("A.drop_flag",  128'(a_drop), 128'(1));
      chk("A.drop_vec",   {48'b0, a_vec}, seqv(1, 10));
      chk("A.drop_valid", 128'(a_ov), 128'(1));
      a_ack_pulse();
      chk("A.ack_valid", 128'(a_ov), 128'(0));
      chk("A.ack_ready", 128'(a_rdy), 128'(1));
      chk("A.ack_cnt",   128'(a_cnt), '0);

      a_send(ch(40, 41, 42, 43));
      a_send(ch(44, 45, 46, 47));
      a_send(ch(48, 49, 50, 51));
      chk("A.v2_vec",    {48'b0, a_vec}, seqv(40, 10));
      chk("A.v2_sticky", 128'(a_drop), 128'(1));

      // ack and strobe together: back to FILLING, chunk dropped
      a_ack = 1'b1; a_v = 1'b1; a_d = ch(77, 77, 77, 77);
      @(negedge clk);
      a_ack = 1'b0; a_v = 1'b0;
      chk("A.both_valid", 128'(a_ov), 128'(0));
      chk("A.both_cnt",   128'(a_cnt), '0);

      // reset mid-vector discards the partial vector and clears drop_err
      a_send(ch(1, 2, 3, 4));
      a_send(ch(5, 6, 7, 8));
      a_rst = 1'b1;
      @(negedge clk);
      a_rst = 1'b0;
      chk("A.mrst_cnt",  128'(a_cnt), '0);
      chk("A.mrst_drop", 128'(a_drop), '0);
      chk("A.mrst_vec",  {48'b0, a_vec}, '0);
      a_send(ch(20, 21, 22, 23));
      a_send(ch(24, 25, 26, 27));
      a_send(ch(28, 29, 30, 31));
      chk("A.rst_fill_vec", {48'b0, a_vec}, seqv(20, 10));
      a_ack_pulse();

      // gapped strobes, with an ack during FILLING that must be ignored
      a_send(ch(60, 61, 62, 63));
      a_ack_pulse();
      chk("A.gap1a_cnt", 128'(a_cnt), 128'(1));
      @(negedge clk);
      chk("A.gap1b_cnt", 128'(a_cnt), 128'(1));
      a_send(ch(64, 65, 66, 67));
      repeat (2) begin
         @(negedge clk);
         chk("A.gap2_cnt", 128'(a_cnt), 128'(2));
      end
      a_send(ch(68, 69, 70, 71));
      chk("A.gap_vec",   {48'b0, a_vec}, seqv(60, 10));
      chk("A.gap_valid", 128'(a_ov), 128'(1));

      // single-chunk vectors with surplus lanes, ack then immediate chunk
      b_v = 1'b1; b_d = ch(-1, -2, -3, -4);
      @(negedge clk);
      b_v = 1'b0;
      chk("B.v1_vec",   {104'b0, b_vec}, {104'b0, 24'hFDFEFF});
      chk("B.v1_valid", 128'(b_ov), 128'(1));
      chk("B.v1_cnt",   128'(b_cnt), 128'(1));
      b_ack = 1'b1;
      @(negedge clk);
      b_ack = 1'b0;
      chk("B.ack_valid", 128'(b_ov), 128'(0));
      chk("B.ack_ready", 128'(b_rdy), 128'(1));
      b_v = 1'b1; b_d = ch(5, 6, 7, 8);
      @(negedge clk);
      b_v = 1'b0;
      chk("B.v2_vec",   {104'b0, b_vec}, {104'b0, 24'h070605});
      chk("B.v2_valid", 128'(b_ov), 128'(1));
      chk("B.v2_drop",  128'(b_drop), '0);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
